// File: rtl/dcache_wb_scheduler.sv
// Dirty-line write-back FIFO: absorbs evictions in one cycle and drains them in order, one line per burst.
// Issue one cycle after an entry is visible; wb_ready_o drops only when full and the line cannot coalesce.
module dcache_wb_scheduler #(
  parameter int DEPTH  = 2,
  parameter int LINE_W = 128,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wb_req_i,
  input  logic [ADDR_W-1:0] wb_addr_i,
  input  logic [LINE_W-1:0] wb_data_i,
  output logic              wb_ready_o,
  input  logic [ADDR_W-1:0] rd_addr_i,
  output logic              rd_fwd_hit_o,
  output logic [LINE_W-1:0] rd_fwd_data_o,
  input  logic              flush_i,
  output logic              empty_o,
  input  logic              bus_wrdy_i,
  input  logic              bus_bvalid_i,
  output logic [3:0]        bus_wen_o,
  output logic [ADDR_W-1:0] bus_awaddr_o,
  output logic [LINE_W-1:0] bus_wdata_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int TW = ADDR_W - 4;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

  state_t            state;
  logic [DEPTH-1:0]  valid_q;
  logic [TW-1:0]     tag_q  [DEPTH];
  logic [LINE_W-1:0] data_q [DEPTH];
  logic [PW-1:0]     head_q;
  logic [PW-1:0]     tail_q;
  logic [CW-1:0]     count_q;
  logic [3:0]        wen_q;

  logic          locked;
  logic          full;
  logic          co_hit;
  logic [PW-1:0] co_idx;
  logic          push;
  logic          alloc;
  logic          pop;
  logic [PW-1:0] fwd_idx;

  // Flush is advisory only: the buffer always drains, the dcache waits on empty_o.
  logic unused_ok;
  assign unused_ok = ^{flush_i, wb_addr_i[3:0], rd_addr_i[3:0]};

  assign locked = (state != IDLE);
  assign full   = (count_q == CW'(DEPTH));

  // The head being written to the bus must not change, so it is excluded from coalescing.
  always_comb begin
    co_hit = 1'b0;
    co_idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid_q[i] && (tag_q[i] == wb_addr_i[ADDR_W-1:4]) && !(locked && (PW'(i) == head_q))) begin
        co_hit = 1'b1;
        co_idx = PW'(i);
      end
    end
  end

  assign wb_ready_o = !full || co_hit;
  assign push       = wb_req_i && wb_ready_o;
  assign alloc      = push && !co_hit;
  assign pop        = (state == WAIT) && bus_bvalid_i;

  // Walk oldest to newest so the last match (closest to tail) wins.
  always_comb begin
    rd_fwd_hit_o  = 1'b0;
    rd_fwd_data_o = '0;
    fwd_idx       = '0;
    for (int k = 0; k < DEPTH; k++) begin
      fwd_idx = head_q + PW'(k);
      if (valid_q[fwd_idx] && (tag_q[fwd_idx] == rd_addr_i[ADDR_W-1:4])) begin
        rd_fwd_hit_o  = 1'b1;
        rd_fwd_data_o = data_q[fwd_idx];
      end
    end
  end

  assign bus_awaddr_o = (count_q != '0) ? {tag_q[head_q], 4'b0000} : '0;
  assign bus_wdata_o  = (count_q != '0) ? data_q[head_q] : '0;
  assign bus_wen_o    = wen_q;
  assign empty_o      = (count_q == '0) && (state == IDLE);

  always_ff @(posedge clk) begin
    if (!rst) begin
      valid_q <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      state   <= IDLE;
      wen_q   <= '0;
    end else begin
      if (push) begin
        if (co_hit) begin
          data_q[co_idx] <= wb_data_i;
        end else begin
          valid_q[tail_q] <= 1'b1;
          tag_q[tail_q]   <= wb_addr_i[ADDR_W-1:4];
          data_q[tail_q]  <= wb_data_i;
          tail_q          <= tail_q + PW'(1);
        end
      end
      if (pop) begin
        valid_q[head_q] <= 1'b0;
        head_q          <= head_q + PW'(1);
      end
      count_q <= count_q + CW'(alloc) - CW'(pop);

      wen_q <= '0;
      case (state)
        IDLE: begin
          if ((count_q != '0) && bus_wrdy_i) begin
            state <= ISSUE;
            wen_q <= 4'b1111;
          end
        end
        ISSUE:   state <= WAIT;
        WAIT:    if (bus_bvalid_i) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dcache_wb_scheduler.sv
// Randomized bench for dcache_wb_scheduler with a queue-based line model and a negedge monitor.
module tb_dcache_wb_scheduler;

  localparam int DEPTH  = 2;
  localparam int LINE_W = 128;
  localparam int ADDR_W = 32;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              wb_req_i = 1'b0;
  logic [ADDR_W-1:0] wb_addr_i = '0;
  logic [LINE_W-1:0] wb_data_i = '0;
  logic              wb_ready_o;
  logic [ADDR_W-1:0] rd_addr_i = '0;
  logic              rd_fwd_hit_o;
  logic [LINE_W-1:0] rd_fwd_data_o;
  logic              flush_i = 1'b0;
  logic              empty_o;
  logic              bus_wrdy_i = 1'b0;
  logic              bus_bvalid_i = 1'b0;
  logic [3:0]        bus_wen_o;
  logic [ADDR_W-1:0] bus_awaddr_o;
  logic [LINE_W-1:0] bus_wdata_o;

  dcache_wb_scheduler #(.DEPTH(DEPTH), .LINE_W(LINE_W), .ADDR_W(ADDR_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .wb_req_i     (wb_req_i),
    .wb_addr_i    (wb_addr_i),
    .wb_data_i    (wb_data_i),
    .wb_ready_o   (wb_ready_o),
    .rd_addr_i    (rd_addr_i),
    .rd_fwd_hit_o (rd_fwd_hit_o),
    .rd_fwd_data_o(rd_fwd_data_o),
    .flush_i      (flush_i),
    .empty_o      (empty_o),
    .bus_wrdy_i   (bus_wrdy_i),
    .bus_bvalid_i (bus_bvalid_i),
    .bus_wen_o    (bus_wen_o),
    .bus_awaddr_o (bus_awaddr_o),
    .bus_wdata_o  (bus_wdata_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [27:0]  line;
    logic [127:0] data;
  } ent_t;

  // Model: lines in drain order; the front is locked once the bus has taken it.
  ent_t mq[$];
  bit   locked     = 0;
  bit   issue_next = 0;
  bit   armed      = 0;
  int   n_cmp      = 0;
  int   n_fail     = 0;
  int   n_issue    = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    bit           exp_wen, exp_ready, exp_hit, nxt_issue;
    int           co;
    logic [127:0] exp_fwd;
    ent_t         e;
    if (armed) begin
      exp_wen = issue_next;
      chk("bus_wen", bus_wen_o, exp_wen ? 4'hF : 4'h0);
      if (exp_wen) begin
        locked = 1;
        n_issue++;
      end
      co = -1;
      foreach (mq[i])
        if (mq[i].line == wb_addr_i[31:4] && !(locked && i == 0)) co = i;
      exp_ready = (mq.size() < DEPTH) || (co >= 0);
      chk("wb_ready", wb_ready_o, exp_ready);
      chk("empty", empty_o, mq.size() == 0);
      chk("awaddr", bus_awaddr_o, mq.size() != 0 ? {mq[0].line, 4'h0} : 32'h0);
      chk("wdata", bus_wdata_o, mq.size() != 0 ? mq[0].data : 128'h0);
      exp_hit = 0;
      exp_fwd = '0;
      foreach (mq[i])
        if (mq[i].line == rd_addr_i[31:4]) begin
          exp_hit = 1;
          exp_fwd = mq[i].data;
        end
      chk("fwd_hit", rd_fwd_hit_o, exp_hit);
      chk("fwd_data", rd_fwd_data_o, exp_fwd);

      nxt_issue = !locked && mq.size() != 0 && bus_wrdy_i;
      if (wb_req_i && exp_ready) begin
        if (co >= 0) mq[co].data = wb_data_i;
        else begin
          e.line = wb_addr_i[31:4];
          e.data = wb_data_i;
          mq.push_back(e);
        end
      end
      if (locked && !exp_wen && bus_bvalid_i) begin
        void'(mq.pop_front());
        locked = 0;
      end
      issue_next = nxt_issue;
    end
    if (rst == 1'b0) begin
      mq.delete();
      locked     = 0;
      issue_next = 0;
      armed      = 1;
    end
  end

  task automatic step(input logic req, input logic [31:0] a, input logic [127:0] d,
                      input logic [31:0] rd, input logic wr, input logic bv);
    wb_req_i     = req;
    wb_addr_i    = a;
    wb_data_i    = d;
    rd_addr_i    = rd;
    bus_wrdy_i   = wr;
    bus_bvalid_i = bv;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n, input logic wr, input logic [31:0] rd);
    for (int i = 0; i < n; i++) step(0, 0, 0, rd, wr, 0);
  endtask

  function automatic logic [127:0] rdata();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  initial begin
    int budget;
    rst = 1'b0;
    idle(3, 1, 32'h0);
    rst = 1'b1;
    idle(4, 1, 32'h1230);

    // Single line drains with wrdy high.
    step(1, 32'h0000_1230, 128'h44444444_33333333_22222222_11111111, 32'h1234, 1, 0);
    idle(4, 1, 32'h1230);
    step(0, 0, 0, 32'h1230, 1, 1);
    idle(3, 1, 32'h1230);

    // Fill, reject, coalesce with the bus stalled.
    step(1, 32'h100, 128'hA1, 32'h200, 0, 0);
    step(1, 32'h200, 128'hB2, 32'h200, 0, 0);
    step(1, 32'h300, 128'hC3, 32'h204, 0, 0);
    step(1, 32'h20C, 128'hB3, 32'h208, 0, 0);
    idle(2, 0, 32'h200);
    for (int i = 0; i < 4; i++) begin
      idle(3, 1, 32'h100);
      step(0, 0, 0, 32'h200, 1, 1);
    end

    // Same line pushed again while its older copy is locked on the bus.
    step(1, 32'h100, 128'hD1, 32'h104, 1, 0);
    idle(3, 1, 32'h104);
    step(1, 32'h100, 128'hD2, 32'h104, 1, 0);
    idle(2, 1, 32'h104);
    for (int i = 0; i < 2; i++) begin
      step(0, 0, 0, 32'h104, 1, 1);
      idle(3, 1, 32'h104);
    end

    // Full with pop and push in the same cycle.
    step(1, 32'h400, 128'hE1, 32'h400, 0, 0);
    step(1, 32'h500, 128'hE2, 32'h500, 0, 0);
    idle(3, 1, 32'h400);
    step(1, 32'h600, 128'hE3, 32'h600, 1, 1);
    step(1, 32'h600, 128'hE3, 32'h600, 0, 0);
    idle(2, 0, 32'h600);

    // Reset while a burst is outstanding with two entries held.
    idle(3, 1, 32'h500);
    rst = 1'b0;
    idle(1, 0, 32'h500);
    rst = 1'b1;
    idle(3, 0, 32'h600);

    for (int c = 0; c < 3000; c++) begin
      logic [31:0] a, r;
      a = ($urandom_range(1, 6) << 8) | ($urandom % 16);
      r = ($urandom_range(1, 6) << 8) | ($urandom % 16);
      rst = ($urandom % 400 == 0) ? 1'b0 : 1'b1;
      step($urandom % 2 == 0, a, rdata(), r, $urandom % 4 != 0, $urandom % 3 == 0);
    end
    rst = 1'b1;

    budget = 0;
    while (empty_o !== 1'b1 && budget < 200) begin
      step(0, 0, 0, 0, 1, 1);
      budget++;
    end
    chk("drain_done", empty_o, 1'b1);
    chk("bursts_seen", n_issue != 0, 1'b1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
